// File: rtl/ps_channel_scheduler.sv
// ps_channel_scheduler: round-robin issue of per-channel EEG samples into one shared
// power-spectrum unit, with an in-order tag FIFO that labels each returning result.
module ps_channel_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int WIN_LEN    = 256,
  parameter int TAG_DEPTH  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_run,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_ch_din,
  input  logic [NUM_CH-1:0]            i_ch_valid,
  output logic [NUM_CH-1:0]            o_ch_ready,
  output logic [DATA_WIDTH-1:0]        o_ps_din,
  output logic                         o_ps_en,
  input  logic [DATA_WIDTH:0]          i_ps_dout,
  input  logic                         i_ps_data_valid,
  output logic [DATA_WIDTH:0]          o_out_data,
  output logic [$clog2(NUM_CH)-1:0]    o_out_ch,
  output logic                         o_out_last,
  output logic                         o_out_valid,
  output logic                         o_err_tag
);
  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int WW = $clog2(WIN_LEN);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;
  state_t          r_state, w_next;
  logic [1:0]      r_sync;
  logic [CW-1:0]   r_rr, w_g;
  logic [WW-1:0]   r_win_cnt [NUM_CH];
  logic [CW:0]     r_tag_mem [TAG_DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [AW:0]     r_count;
  logic            w_found, w_full, w_grant, w_pop, w_last;
  // First valid channel at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_g     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int k;
      k = int'(r_rr) + i;
      if (k >= NUM_CH) k = k - NUM_CH;
      if (!w_found && i_ch_valid[k]) begin
        w_found = 1'b1;
        w_g     = CW'(k);
      end
    end
  end
  assign w_full  = r_count == (AW+1)'(TAG_DEPTH);
  assign w_grant = w_found & i_run & ~w_full & r_sync[1];
  assign w_pop   = i_ps_data_valid & (r_count != '0);
  assign w_last  = r_win_cnt[w_g] == WW'(WIN_LEN-1);
  // Grants wait for two clocks after reset release so issue starts cleanly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[0], 1'b1};
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end
  always_comb begin
    w_next = w_grant ? S_ISSUE : (r_count != '0) ? S_DRAIN : S_IDLE;
  end
  always_comb begin
    o_ch_ready = w_grant ? (NUM_CH'(1) << w_g) : '0;
  end
  always_ff @(posedge i_clk) begin
    if (w_grant) r_tag_mem[r_wr] <= {w_g, w_last};
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr        <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      o_ps_din    <= '0;
      o_ps_en     <= 1'b0;
      o_out_data  <= '0;
      o_out_ch    <= '0;
      o_out_last  <= 1'b0;
      o_out_valid <= 1'b0;
      o_err_tag   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_win_cnt[i] <= '0;
    end else begin
      o_ps_en     <= w_grant;
      o_out_valid <= w_pop;
      r_count     <= r_count + (AW+1)'(w_grant) - (AW+1)'(w_pop);
      if (w_grant) begin
        r_rr           <= (w_g == CW'(NUM_CH-1)) ? '0 : w_g + 1'b1;
        r_wr           <= r_wr + 1'b1;
        o_ps_din       <= i_ch_din[w_g*DATA_WIDTH +: DATA_WIDTH];
        r_win_cnt[w_g] <= w_last ? '0 : r_win_cnt[w_g] + 1'b1;
      end
      if (w_pop) begin
        r_rd                   <= r_rd + 1'b1;
        o_out_data             <= i_ps_dout;
        {o_out_ch, o_out_last} <= r_tag_mem[r_rd];
      end
      if (i_ps_data_valid && r_count == '0) o_err_tag <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ps_channel_scheduler.sv
// tb_ps_channel_scheduler: directed checks of grant order, tagging, window flags,
// backpressure, run/drain and error/reset behaviour against a queue-based unit model.
module tb_ps_channel_scheduler;
  localparam int NC = 4, DW = 32;
  typedef struct {logic [DW:0] d; logic [1:0] ch; logic last;} res_t;
  logic            clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic [NC*DW-1:0] ch_din = '0;
  logic [NC-1:0]   ch_valid = '0, ch_ready;
  logic [DW-1:0]   ps_din;
  logic            ps_en, ps_dv = 1'b0, out_last, out_valid, err_tag;
  logic [DW:0]     ps_dout = '0, out_data;
  logic [1:0]      out_ch;
  int              n_checks = 0, n_err = 0, credits = 0;
  bit              inject = 1'b0;
  logic [DW-1:0]   uq [$];
  res_t            rq [$];
  int              gq [$];
  logic [DW-1:0]   pq [$];

  ps_channel_scheduler #(.NUM_CH(NC), .DATA_WIDTH(DW), .WIN_LEN(4), .TAG_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_ch_din(ch_din), .i_ch_valid(ch_valid),
    .o_ch_ready(ch_ready), .o_ps_din(ps_din), .o_ps_en(ps_en), .i_ps_dout(ps_dout),
    .i_ps_data_valid(ps_dv), .o_out_data(out_data), .o_out_ch(out_ch), .o_out_last(out_last),
    .o_out_valid(out_valid), .o_err_tag(err_tag));

  always #5 clk = ~clk;

  // Unit model: accepts every ps_en sample, returns sample+5000 when credits allow.
  always @(negedge clk) begin
    if (ps_en) uq.push_back(ps_din);
    if (inject) begin
      ps_dv = 1'b1; ps_dout = '0;
    end else if (credits > 0 && uq.size() > 0) begin
      ps_dv = 1'b1; ps_dout = {1'b0, uq.pop_front()} + 33'd5000; credits--;
    end else ps_dv = 1'b0;
  end

  always @(negedge clk) begin
    if (out_valid) rq.push_back('{out_data, out_ch, out_last});
    if (ps_en) pq.push_back(ps_din);
    for (int i = 0; i < NC; i++) if (ch_ready[i]) gq.push_back(i);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; ch_valid = '0; credits = 0; inject = 1'b0;
    tick(1);
    uq.delete(); rq.delete(); gq.delete(); pq.delete();
    rst_n = 1'b1;
    tick(3);
  endtask

  initial begin
    #2;
    check("rst_ready", 64'(ch_ready), 0);
    check("rst_ps_en", 64'(ps_en), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_data", 64'(out_data), 0);
    check("rst_err", 64'(err_tag), 0);
    do_reset();

    // Single channel, din 10,20,30,40
    run = 1'b1; credits = 1000;
    for (int k = 0; k < 4; k++) begin
      ch_din[31:0] = 32'(10*(k+1)); ch_valid = 4'b0001;
      tick(1);
    end
    ch_valid = '0;
    tick(6);
    check("single_grants", gq.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("single_g%0d", k), gq[k], 0);
      check($sformatf("single_ps%0d", k), pq[k], 10*(k+1));
      check($sformatf("single_d%0d", k), rq[k].d, 5000 + 10*(k+1));
      check($sformatf("single_ch%0d", k), rq[k].ch, 0);
    end
    check("single_last3", rq[3].last, 1);

    // Round robin, all valid for 6 grants
    do_reset();
    run = 1'b1; credits = 1000;
    ch_din = {32'd103, 32'd102, 32'd101, 32'd100}; ch_valid = 4'b1111;
    tick(6);
    ch_valid = '0;
    tick(6);
    begin
      int exp_o [6] = '{0, 1, 2, 3, 0, 1};
      check("rr_results", rq.size(), 6);
      for (int k = 0; k < 6; k++) begin
        check($sformatf("rr_g%0d", k), gq[k], exp_o[k]);
        check($sformatf("rr_ch%0d", k), rq[k].ch, exp_o[k]);
        check($sformatf("rr_d%0d", k), rq[k].d, 5100 + exp_o[k]);
      end
    end

    // Window flag on channel 2, 9 samples
    do_reset();
    run = 1'b1; credits = 1000;
    for (int k = 0; k < 9; k++) begin
      ch_din[64 +: 32] = 32'(k); ch_valid = 4'b0100;
      tick(1);
    end
    ch_valid = '0;
    tick(6);
    check("win_results", rq.size(), 9);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("win_last%0d", k), rq[k].last, (k == 3 || k == 7) ? 1 : 0);
      check($sformatf("win_ch%0d", k), rq[k].ch, 2);
    end
    check("win_cnt2", 64'(dut.r_win_cnt[2]), 1);

    // Backpressure with tag depth 4
    do_reset();
    run = 1'b1; credits = 0; ch_din[31:0] = 32'd7; ch_valid = 4'b0001;
    tick(8);
    check("bp_grants", gq.size(), 4);
    check("bp_ready", 64'(ch_ready), 0);
    credits = 1;
    tick(6);
    check("bp_grants_after", gq.size(), 5);
    check("bp_count", 64'(dut.r_count), 4);
    check("bp_ready2", 64'(ch_ready), 0);
    check("bp_one_result", rq.size(), 1);
    ch_valid = '0; credits = 1000;
    tick(8);
    check("bp_drained", rq.size(), 5);

    // run drop with 3 in flight, then resume
    do_reset();
    credits = 0; ch_din = {32'd3, 32'd2, 32'd1, 32'd0}; ch_valid = 4'b1111; run = 1'b1;
    tick(3);
    run = 1'b0;
    tick(2);
    check("drain_grants", gq.size(), 3);
    check("drain_ready", 64'(ch_ready), 0);
    check("drain_state", 64'(dut.r_state), 2);
    credits = 1000;
    tick(6);
    check("drain_results", rq.size(), 3);
    for (int k = 0; k < 3; k++) check($sformatf("drain_ch%0d", k), rq[k].ch, k);
    check("idle_state", 64'(dut.r_state), 0);
    run = 1'b1;
    tick(1);
    run = 1'b0;
    tick(1);
    check("resume_g", gq[3], 3);
    ch_valid = '0;
    tick(4);

    // Error tag and async reset
    inject = 1'b1;
    tick(1);
    inject = 1'b0;
    tick(3);
    check("err_set", 64'(err_tag), 1);
    check("err_no_out", rq.size(), 4);
    run = 1'b1; ch_din[31:0] = 32'd9; ch_valid = 4'b0001;
    tick(3);
    check("err_sticky", 64'(err_tag), 1);
    check("pre_rst_valid", 64'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_err", 64'(err_tag), 0);
    check("arst_ps_en", 64'(ps_en), 0);
    check("arst_out_valid", 64'(out_valid), 0);
    check("arst_out_data", 64'(out_data), 0);
    check("arst_ready", 64'(ch_ready), 0);
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
